// File: rtl/entity_slot_scheduler.sv
// rtl/entity_slot_scheduler.sv - round-robin entity slot writer with vblank-synchronous bank swap
// Shadow bank takes requester writes; active bank drives the frame buffer and updates only on vblank.
module entity_slot_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_SLOTS = 9,
  parameter int ENT_W     = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [4*NUM_REQ-1:0]       req_slot,
  input  logic [ENT_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       vblank_start,
  output logic [ENT_W*NUM_SLOTS-1:0] entity_flat,
  output logic                       frame_swap,
  output logic                       slot_err,
  output logic                       dirty
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ENT_W-1:0] EMPTY_ENT = {4'hf, {(ENT_W-4){1'b0}}};

  typedef enum logic {
    OPEN = 1'b0,
    SWAP = 1'b1
  } state_t;

  state_t state, next_state;

  logic [PTR_W-1:0] ptr, next_ptr;
  logic [ENT_W-1:0] shadow [NUM_SLOTS];
  logic [ENT_W-1:0] active [NUM_SLOTS];

  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  logic [3:0]         sel_slot;
  logic [ENT_W-1:0]   sel_data;
  logic               slot_ok;
  int                 idx;

  // Search starts at the pointer and wraps; the first valid requester wins.
  always_comb begin
    grant    = '0;
    xfer     = 1'b0;
    sel_slot = '0;
    sel_data = '0;
    next_ptr = ptr;
    idx      = 0;
    if (state == OPEN) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = (int'(ptr) + i) % NUM_REQ;
        if (!xfer && req_valid[idx]) begin
          xfer       = 1'b1;
          grant[idx] = 1'b1;
          sel_slot   = req_slot[idx*4 +: 4];
          sel_data   = req_data[idx*ENT_W +: ENT_W];
          next_ptr   = PTR_W'((idx + 1) % NUM_REQ);
        end
      end
    end
  end

  assign req_ready = grant;
  assign slot_ok   = (sel_slot < 4'(NUM_SLOTS));

  always_comb begin
    next_state = state;
    case (state)
      OPEN: if (vblank_start && (dirty || (xfer && slot_ok))) next_state = SWAP;
      SWAP: next_state = OPEN;
      default: next_state = OPEN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= OPEN;
      ptr   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  // Invalid-slot writes are granted but dropped so the requester never stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        shadow[k] <= EMPTY_ENT;
        active[k] <= EMPTY_ENT;
      end
      dirty      <= 1'b0;
      frame_swap <= 1'b0;
      slot_err   <= 1'b0;
    end else begin
      frame_swap <= (state == SWAP);
      slot_err   <= xfer && !slot_ok;
      if (xfer && slot_ok) begin
        shadow[sel_slot] <= sel_data;
      end
      if (state == SWAP) begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          active[k] <= shadow[k];
        end
        dirty <= 1'b0;
      end else if (xfer && slot_ok) begin
        dirty <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_flat
    assign entity_flat[k*ENT_W +: ENT_W] = active[k];
  end

endmodule

// File: tb/tb_entity_slot_scheduler.sv
// tb/tb_entity_slot_scheduler.sv - directed self-checking bench for entity_slot_scheduler
module tb_entity_slot_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [15:0]  req_slot;
  logic [55:0]  req_data;
  logic [3:0]   req_ready;
  logic         vblank_start;
  logic [125:0] entity_flat;
  logic         frame_swap;
  logic         slot_err;
  logic         dirty;

  logic [125:0] exp_flat;
  int           n_tests = 0;
  int           n_fail  = 0;

  entity_slot_scheduler #(.NUM_REQ(4), .NUM_SLOTS(9), .ENT_W(14)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_slot     (req_slot),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .vblank_start (vblank_start),
    .entity_flat  (entity_flat),
    .frame_swap   (frame_swap),
    .slot_err     (slot_err),
    .dirty        (dirty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = '0;
    req_slot     = '0;
    req_data     = '0;
    vblank_start = 1'b0;
    exp_flat     = {9{14'h3C00}};

    // Reset state
    #12;
    chk("rst_flat", entity_flat, exp_flat);
    chk("rst_swap", frame_swap, 1'b0);
    chk("rst_err", slot_err, 1'b0);
    chk("rst_dirty", dirty, 1'b0);
    chk("rst_ready", req_ready, 4'b0000);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // vblank with nothing pending: no swap
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    chk("idle_vb_swap1", frame_swap, 1'b0);
    tick();
    chk("idle_vb_swap2", frame_swap, 1'b0);
    chk("idle_vb_flat", entity_flat, exp_flat);
    tick();
    chk("idle_vb_swap3", frame_swap, 1'b0);

    // Requester 1 writes slot 2, then vblank
    req_valid         = 4'b0010;
    req_slot[7:4]     = 4'd2;
    req_data[27:14]   = 14'h0A35;
    #1;
    chk("w1_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    chk("w1_dirty", dirty, 1'b1);
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    chk("w1_swapcyc_dirty", dirty, 1'b1);
    chk("w1_swapcyc_fs", frame_swap, 1'b0);
    chk("w1_swapcyc_flat", entity_flat, exp_flat);
    tick();
    exp_flat[28 +: 14] = 14'h0A35;
    chk("w1_flat", entity_flat, exp_flat);
    chk("w1_fs", frame_swap, 1'b1);
    chk("w1_dirty_clr", dirty, 1'b0);
    tick();
    chk("w1_fs_drop", frame_swap, 1'b0);

    // Round robin with all four requesters valid, pointer at 0
    pulse_reset();
    exp_flat  = {9{14'h3C00}};
    req_slot  = {4'd3, 4'd2, 4'd1, 4'd0};
    req_data  = {14'h0003, 14'h0002, 14'h0001, 14'h0000};
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rr_all_%0d", i), req_ready, 4'b0001 << (i % 4));
      tick();
    end
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_13_%0d", i), req_ready, (i % 2 == 0) ? 4'b0010 : 4'b1000);
      tick();
    end
    req_valid = '0;

    // Last write wins, second write lands in the vblank cycle
    pulse_reset();
    req_valid      = 4'b0001;
    req_slot[3:0]  = 4'd5;
    req_data[13:0] = 14'h1111;
    #1;
    chk("lw_first_ready", req_ready, 4'b0001);
    tick();
    req_valid        = 4'b0100;
    req_slot[11:8]   = 4'd5;
    req_data[41:28]  = 14'h2222;
    vblank_start     = 1'b1;
    #1;
    chk("lw_vb_ready", req_ready, 4'b0100);
    tick();
    vblank_start = 1'b0;
    #1;
    chk("lw_swap_ready", req_ready, 4'b0000);
    tick();
    req_valid = '0;
    exp_flat[70 +: 14] = 14'h2222;
    chk("lw_flat", entity_flat, exp_flat);
    chk("lw_fs", frame_swap, 1'b1);

    // Invalid slot: granted, dropped, slot_err next cycle, no swap
    req_valid     = 4'b0001;
    req_slot[3:0] = 4'd12;
    req_data[13:0] = 14'h3FFF;
    #1;
    chk("bad_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("bad_err", slot_err, 1'b1);
    chk("bad_dirty", dirty, 1'b0);
    tick();
    chk("bad_err_drop", slot_err, 1'b0);
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    chk("bad_vb_fs1", frame_swap, 1'b0);
    tick();
    chk("bad_vb_fs2", frame_swap, 1'b0);
    chk("bad_vb_flat", entity_flat, exp_flat);

    // Async reset mid-cycle after three shadow writes
    req_valid = 4'b0001;
    req_slot[3:0] = 4'd0;
    req_data[13:0] = 14'h0101;
    tick();
    req_slot[3:0] = 4'd1;
    req_data[13:0] = 14'h0202;
    tick();
    req_slot[3:0] = 4'd3;
    req_data[13:0] = 14'h0303;
    tick();
    req_valid = '0;
    chk("ar_dirty_pre", dirty, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    exp_flat = {9{14'h3C00}};
    chk("ar_flat", entity_flat, exp_flat);
    chk("ar_dirty", dirty, 1'b0);
    chk("ar_fs", frame_swap, 1'b0);
    chk("ar_err", slot_err, 1'b0);
    #1;
    reset = 1'b0;
    tick();
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    chk("ar_vb_fs1", frame_swap, 1'b0);
    tick();
    chk("ar_vb_fs2", frame_swap, 1'b0);
    chk("ar_vb_flat", entity_flat, exp_flat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
